// File: rtl/memory_bus_router_if.sv
// Bus bundle between the CPU/region side and memory_bus_router.
// Carries the CPU request/response, the one-hot region strobes, region data and ready, and error flag/clear.
// master: the CPU and region environment that drives requests and ready. slave: the router itself.
interface memory_bus_router_if #(
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 8,
  parameter int REGION_BITS = 2
);
  localparam int NUM_REGIONS = 2 ** REGION_BITS;

  // CPU side
  logic [ADDR_WIDTH-1:0]              address;
  logic [DATA_WIDTH-1:0]              data_in;
  logic [DATA_WIDTH-1:0]              data_out;
  logic                               bus_enable;
  logic                               write_enable;
  logic                               bus_halt;
  // Region side
  logic [NUM_REGIONS-1:0]             region_sel;
  logic                               region_write;
  logic [ADDR_WIDTH-1:0]              region_address;
  logic [DATA_WIDTH-1:0]              region_wdata;
  logic [NUM_REGIONS*DATA_WIDTH-1:0]  region_rdata;
  logic [NUM_REGIONS-1:0]             region_ready;
  // Error reporting
  logic                               bus_error;
  logic                               err_clear;

  modport master (
    output address, data_in, bus_enable, write_enable, region_rdata, region_ready, err_clear,
    input  data_out, bus_halt, region_sel, region_write, region_address, region_wdata, bus_error
  );

  modport slave (
    input  address, data_in, bus_enable, write_enable, region_rdata, region_ready, err_clear,
    output data_out, bus_halt, region_sel, region_write, region_address, region_wdata, bus_error
  );
endinterface

// File: rtl/memory_bus_router.sv
// Routes one CPU access at a time to one of 2**REGION_BITS memory regions and returns read data.
// Latency: 3 cycles minimum (IDLE request, ACCESS, DONE); ACCESS lasts until the selected region is ready.
// Backpressure: bus_halt stalls the CPU from the request cycle until the access completes.
//
// Ports: clk (sole clock), reset (async, active low), bus (memory_bus_router_if.slave).
// Optional feature macro BUS_TIMEOUT_EN: adds a 16-bit access timeout that forces DONE after
// TIMEOUT_CYCLES ACCESS cycles, returns all-ones on reads and raises the sticky bus_error.
// Without it ACCESS waits indefinitely and bus_error is tied low.
module memory_bus_router #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 8,
  parameter int REGION_BITS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  memory_bus_router_if.slave  bus
);
  localparam int NUM_REGIONS = 2 ** REGION_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [REGION_BITS-1:0]  dec_idx;
  logic [REGION_BITS-1:0]  reg_idx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [DATA_WIDTH-1:0]   rdata_slice;
  logic                    ready_hit;
  logic                    timeout_hit;
  logic                    start_access;
  logic                    halt_c;
  logic [NUM_REGIONS-1:0]  sel_c;

  // Anything above the low 64 KiB window lands in the last region.
  always_comb begin
    if (bus.address[ADDR_WIDTH-1:16] != '0) begin
      dec_idx = '1;
    end else begin
      dec_idx = bus.address[15 -: REGION_BITS];
    end
  end

  assign start_access = (state == IDLE) && bus.bus_enable;
  // Only the latched region's ready bit matters; the others are don't-care.
  assign ready_hit    = bus.region_ready[reg_idx];
  assign rdata_slice  = bus.region_rdata[int'(reg_idx) * DATA_WIDTH +: DATA_WIDTH];

`ifdef BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_q;

  // The timeout cycle is the ACCESS cycle in which the counter would reach TIMEOUT_CYCLES;
  // a ready in that same cycle still wins.
  assign timeout_hit = (state == ACCESS) && !ready_hit &&
                       (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (start_access) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A timeout in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if (bus.err_clear) begin
      err_q <= 1'b0;
    end
  end

  assign bus.bus_error = err_q;
`else
  logic unused_err_clear;

  assign timeout_hit      = 1'b0;
  assign bus.bus_error    = 1'b0;
  assign unused_err_clear = bus.err_clear;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.bus_enable) state_nxt = ACCESS;
      ACCESS:  if (ready_hit || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    halt_c = 1'b0;
    sel_c  = '0;
    case (state)
      IDLE:    halt_c = bus.bus_enable;
      ACCESS: begin
        halt_c         = 1'b1;
        sel_c[reg_idx] = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch: held from ACCESS entry until the next accepted request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      reg_idx <= '0;
    end else if (start_access) begin
      addr_q  <= bus.address;
      wdata_q <= bus.data_in;
      write_q <= bus.write_enable;
      reg_idx <= dec_idx;
    end
  end

  // Read data return; writes leave data_out untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
    end else if ((state == ACCESS) && !write_q) begin
      if (ready_hit) begin
        dout_q <= rdata_slice;
      end else if (timeout_hit) begin
        dout_q <= '1;
      end
    end
  end

  // Halt is gated by reset so the CPU is never stalled while the block is held in reset.
  assign bus.bus_halt       = reset & halt_c;
  assign bus.region_sel     = sel_c;
  assign bus.region_address = addr_q;
  assign bus.region_wdata   = wdata_q;
  assign bus.region_write   = write_q;
  assign bus.data_out       = dout_q;
endmodule

// File: tb/tb_memory_bus_router.sv
// Directed bench for memory_bus_router with a transaction-level reference model
// and a per-cycle compare process; directed literal checks pin key scenarios.
module tb_memory_bus_router;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
  localparam int TO     = 4;
`else
  localparam bit TMO_EN = 1'b0;
  localparam int TO     = 255;
`endif

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  memory_bus_router_if #(.ADDR_WIDTH(24), .DATA_WIDTH(8), .REGION_BITS(2)) bus_if ();

  memory_bus_router #(
    .ADDR_WIDTH(24), .DATA_WIDTH(8), .REGION_BITS(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Region selection as plain arithmetic on the address value.
  function automatic int decode(input logic [23:0] a);
    if (a >= 24'h010000) return 3;
    return (int'(a) / 16384) % 4;
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy, m_done, m_write, m_err;
  int          m_r, m_cnt;
  logic [23:0] m_addr;
  logic [7:0]  m_wdata, m_dout;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_done <= 0; m_write <= 0; m_err <= 0;
      m_r <= 0; m_cnt <= 0; m_addr <= '0; m_wdata <= '0; m_dout <= '0;
    end else begin
      if (m_done) begin
        m_done <= 0;
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (bus_if.region_ready[m_r]) begin
          m_busy <= 0; m_done <= 1;
          if (!m_write) m_dout <= bus_if.region_rdata[m_r*8 +: 8];
        end else if (TMO_EN && m_cnt == TO - 1) begin
          m_busy <= 0; m_done <= 1;
          if (!m_write) m_dout <= 8'hFF;
        end
      end else if (bus_if.bus_enable) begin
        m_busy <= 1; m_cnt <= 0; m_r <= decode(bus_if.address);
        m_addr <= bus_if.address; m_wdata <= bus_if.data_in; m_write <= bus_if.write_enable;
      end
      if (TMO_EN) begin
        if (m_busy && !bus_if.region_ready[m_r] && m_cnt == TO - 1) m_err <= 1;
        else if (bus_if.err_clear) m_err <= 0;
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      chk("halt",  32'(bus_if.bus_halt),  32'(m_busy || (!m_done && bus_if.bus_enable)));
      chk("sel",   32'(bus_if.region_sel), m_busy ? (32'd1 << m_r) : 32'd0);
      chk("dout",  32'(bus_if.data_out),  32'(m_dout));
      chk("err",   32'(bus_if.bus_error), 32'(m_err));
      chk("raddr", 32'(bus_if.region_address), 32'(m_addr));
      chk("wdata", 32'(bus_if.region_wdata), 32'(m_wdata));
      chk("rwr",   32'(bus_if.region_write), 32'(m_write));
    end
  end

  // One access: request in IDLE, scramble CPU inputs during ACCESS, raise ready on the
  // decoded region in ACCESS cycle ready_after (never if negative). Returns at the DONE negedge.
  task automatic run_access(input logic [23:0] a, input logic wr, input logic [7:0] wd,
                            input int ready_after, input bit noise,
                            output int halt_n, output int sel_n, output logic [3:0] sel_seen);
    int r;
    bit ended;
    logic [3:0] mask;
    r = decode(a);
    mask = 4'(1 << r);
    halt_n = 0; sel_n = 0; sel_seen = '0; ended = 0;
    @(posedge clk); #1;
    bus_if.address = a; bus_if.data_in = wd; bus_if.write_enable = wr; bus_if.bus_enable = 1'b1;
    bus_if.region_ready = (ready_after == 0) ? mask : 4'b0000;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus_if.region_sel != 4'b0000) begin sel_n++; sel_seen = bus_if.region_sel; end
      if (!bus_if.bus_halt) begin ended = 1; break; end
      halt_n++;
      @(posedge clk); #1;
      bus_if.bus_enable = 1'b0;
      bus_if.address = a ^ 24'hFFFFFF; bus_if.data_in = ~wd; bus_if.write_enable = ~wr;
      bus_if.region_ready = noise ? (((k % 2) != 0 ? 4'b1011 : 4'b0111) & ~mask) : 4'b0000;
      if (ready_after >= 0 && k >= ready_after) bus_if.region_ready = bus_if.region_ready | mask;
    end
    if (!ended) chk("access_bound", 32'd400, 32'd0);
  endtask

  int h, sn;
  logic [3:0] ss;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus_if.address = 24'h004010; bus_if.data_in = 8'h00; bus_if.bus_enable = 1'b1;
    bus_if.write_enable = 1'b0; bus_if.region_ready = 4'b1111; bus_if.err_clear = 1'b0;
    bus_if.region_rdata = {8'h33, 8'h22, 8'hA5, 8'h11};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_halt", 32'(bus_if.bus_halt), 0);
    chk("rst_sel", 32'(bus_if.region_sel), 0);
    chk("rst_dout", 32'(bus_if.data_out), 0);
    chk("rst_raddr", 32'(bus_if.region_address), 0);
    chk("rst_err", 32'(bus_if.bus_error), 0);
    @(posedge clk); #1;
    bus_if.bus_enable = 1'b0; bus_if.region_ready = 4'b0000;
    reset = 1'b1;

    // Read region 1, ready already high
    run_access(24'h004010, 1'b0, 8'h00, 0, 0, h, sn, ss);
    chk("rd1_halt", 32'(h), 2);
    chk("rd1_seln", 32'(sn), 1);
    chk("rd1_sel", 32'(ss), 32'b0010);
    chk("rd1_dout", 32'(bus_if.data_out), 32'hA5);

    // Write via upper-address decode to region 3
    run_access(24'h012345, 1'b1, 8'h3C, 0, 0, h, sn, ss);
    chk("wr3_sel", 32'(ss), 32'b1000);
    chk("wr3_wdata", 32'(bus_if.region_wdata), 32'h3C);
    chk("wr3_rwr", 32'(bus_if.region_write), 1);
    chk("wr3_dout", 32'(bus_if.data_out), 32'hA5);

    // Region 2 read, ready delayed, other ready bits toggling
    bus_if.region_rdata = {8'h33, 8'h5A, 8'hA5, 8'h11};
    run_access(24'h008000, 1'b0, 8'h00, 9, 1, h, sn, ss);
    chk("rd2_halt", 32'(h), 11);
    chk("rd2_sel", 32'(ss), 32'b0100);
    chk("rd2_dout", 32'(bus_if.data_out), 32'h5A);

    // Region 0 read
    run_access(24'h003FFF, 1'b0, 8'h00, 0, 0, h, sn, ss);
    chk("rd0_sel", 32'(ss), 32'b0001);
    chk("rd0_dout", 32'(bus_if.data_out), 32'h11);

    // Back-to-back with bus_enable held; address change during ACCESS ignored
    @(posedge clk); #1;
    bus_if.region_ready = 4'b1111;
    bus_if.address = 24'h004000; bus_if.write_enable = 1'b0; bus_if.bus_enable = 1'b1;
    @(posedge clk); #1;
    bus_if.address = 24'h00C001;
    @(negedge clk);
    chk("b2b_addr1", 32'(bus_if.region_address), 32'h004000);
    @(negedge clk);
    chk("b2b_done_halt", 32'(bus_if.bus_halt), 0);
    chk("b2b_dout1", 32'(bus_if.data_out), 32'hA5);
    @(negedge clk);
    chk("b2b_idle_halt", 32'(bus_if.bus_halt), 1);
    @(posedge clk); #1;
    bus_if.bus_enable = 1'b0;
    @(negedge clk);
    chk("b2b_addr2", 32'(bus_if.region_address), 32'h00C001);
    chk("b2b_sel2", 32'(bus_if.region_sel), 32'b1000);
    @(negedge clk);
    chk("b2b_dout2", 32'(bus_if.data_out), 32'h33);

`ifdef BUS_TIMEOUT_EN
    run_access(24'h004000, 1'b0, 8'h00, -1, 0, h, sn, ss);
    chk("to_halt", 32'(h), 5);
    chk("to_dout", 32'(bus_if.data_out), 32'hFF);
    chk("to_err", 32'(bus_if.bus_error), 1);
    @(posedge clk); #1; bus_if.err_clear = 1'b1;
    @(posedge clk); #1; bus_if.err_clear = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(bus_if.bus_error), 0);
    bus_if.err_clear = 1'b1;
    run_access(24'h010000, 1'b1, 8'h77, -1, 0, h, sn, ss);
    chk("to_err_win", 32'(bus_if.bus_error), 1);
    chk("to_wr_dout", 32'(bus_if.data_out), 32'hFF);
    @(posedge clk); #1; bus_if.err_clear = 1'b0;
    run_access(24'h008000, 1'b0, 8'h00, 3, 0, h, sn, ss);
    chk("to_edge_halt", 32'(h), 5);
    chk("to_edge_dout", 32'(bus_if.data_out), 32'h5A);
    chk("to_edge_err", 32'(bus_if.bus_error), 0);
`else
    @(posedge clk); #1; bus_if.err_clear = 1'b1;
    @(posedge clk); #1; bus_if.err_clear = 1'b0;
    run_access(24'h008000, 1'b0, 8'h00, 300, 0, h, sn, ss);
    chk("wait_halt", 32'(h), 302);
    chk("wait_dout", 32'(bus_if.data_out), 32'h5A);
    chk("wait_err", 32'(bus_if.bus_error), 0);
`endif

    // Reset mid-ACCESS
    @(posedge clk); #1;
    bus_if.region_ready = 4'b0000;
    bus_if.address = 24'h004010; bus_if.write_enable = 1'b0; bus_if.bus_enable = 1'b1;
    @(posedge clk); #1;
    bus_if.bus_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_sel", 32'(bus_if.region_sel), 32'b0010);
    #2 reset = 1'b0;
    #1;
    chk("abort_halt", 32'(bus_if.bus_halt), 0);
    chk("abort_sel0", 32'(bus_if.region_sel), 0);
    chk("abort_dout", 32'(bus_if.data_out), 0);
    chk("abort_raddr", 32'(bus_if.region_address), 0);
    chk("abort_err", 32'(bus_if.bus_error), 0);
    #1 reset = 1'b1;
    run_access(24'h004010, 1'b0, 8'h00, 0, 0, h, sn, ss);
    chk("post_halt", 32'(h), 2);
    chk("post_dout", 32'(bus_if.data_out), 32'hA5);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memory_bus_router.md
MEMORY_BUS_ROUTER -- requirements
Module: memory_bus_router

Interface
REQ-001 Parameter ADDR_WIDTH, default 24, SHALL set the CPU and region address width (min 17).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the data width.
REQ-003 Parameter REGION_BITS, default 2, SHALL set the region count NUM_REGIONS = 2**REGION_BITS (1..3).
REQ-004 Parameter TIMEOUT_CYCLES, default 255, SHALL set the access timeout in clk cycles (1..65535).
REQ-005 Clocking and reset SHALL be fixed as one clock, with an asynchronous, active-low reset.
REQ-006 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port address, input, ADDR_WIDTH: CPU address.
REQ-009 Port data_in, input, DATA_WIDTH: CPU write data.
REQ-010 Port data_out, output, DATA_WIDTH: registered read data to the CPU.
REQ-011 Port bus_enable, input, 1: CPU access request.
REQ-012 Port write_enable, input, 1: 1 = write, 0 = read; sampled with bus_enable.
REQ-013 Port bus_halt, output, 1: stalls the CPU while an access is in flight.
REQ-014 Port region_sel, output, NUM_REGIONS: one-hot region strobe.
REQ-015 Port region_write, output, 1: latched write_enable.
REQ-016 Port region_address, output, ADDR_WIDTH: latched address.
REQ-017 Port region_wdata, output, DATA_WIDTH: latched data_in.
REQ-018 Port region_rdata, input, NUM_REGIONS*DATA_WIDTH: read data; region r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-019 Port region_ready, input, NUM_REGIONS: per-region completion.
REQ-020 Port bus_error, output, 1: sticky timeout flag.
REQ-021 Port err_clear, input, 1: synchronous clear of bus_error.

Function
REQ-022 Region decode SHALL be: if address[ADDR_WIDTH-1:16] != 0, then r = NUM_REGIONS-1; else r = address[15 -: REGION_BITS].
REQ-023 The FSM SHALL have exactly the states IDLE, ACCESS and DONE.
REQ-024 In IDLE with bus_enable=1, the block SHALL latch address, data_in, write_enable and r, and enter ACCESS next cycle.
REQ-025 bus_halt SHALL be combinationally 1 in IDLE whenever bus_enable=1, 1 throughout ACCESS, and 0 in DONE and idle IDLE.
REQ-026 In ACCESS, region_sel[r] SHALL be 1 and all other region_sel bits 0; region_sel SHALL be all-zero in IDLE and DONE.
REQ-027 region_address, region_wdata and region_write SHALL hold their latched values, unchanged, from ACCESS entry until the next IDLE latch.
REQ-028 In ACCESS with region_ready[r]=1, the block SHALL enter DONE next cycle.
REQ-029 On a read completion, the region r slice of region_rdata SHALL be captured into data_out.
REQ-030 On a write completion, data_out SHALL be unchanged.
REQ-031 region_ready bits other than bit r SHALL be ignored.
REQ-032 Minimum access SHALL be 3 cycles (IDLE→ACCESS→DONE) when ready is already high at ACCESS entry.
REQ-033 DONE SHALL last exactly 1 cycle, then go to IDLE.
REQ-034 bus_enable still high in the following IDLE SHALL start a new access.
REQ-035 bus_enable and address changes during ACCESS or DONE SHALL be ignored.

Reset
REQ-036 When reset=0, asynchronously: state=IDLE, data_out=0, region_sel=0, region_write=0, region_address=0, region_wdata=0, bus_error=0, and the timeout counter=0.
REQ-037 bus_halt SHALL be 0 while reset=0.
REQ-038 Reset asserted mid-ACCESS SHALL abort the access, with no data_out capture.

Configuration
REQ-039 With BUS_TIMEOUT_EN defined:
- a 16-bit counter SHALL clear on ACCESS entry and increment each ACCESS cycle;
- when the counter reaches TIMEOUT_CYCLES with ready low, the FSM SHALL enter DONE, data_out SHALL be all ones (reads only), and bus_error SHALL be set;
- ready=1 in the timeout cycle SHALL win: normal completion, no error;
- err_clear=1 SHALL clear bus_error next cycle, but a timeout in the same cycle SHALL win and leave bus_error set.
REQ-040 Without BUS_TIMEOUT_EN: no counter; ACCESS SHALL wait indefinitely; bus_error SHALL be constant 0; err_clear SHALL be ignored.

Verification
REQ-041 Read, address 0x004010, region_ready[1] held 1, region_rdata slice1=0xA5 → region_sel=0010 for one cycle; data_out=0xA5 in DONE; bus_halt high 2 cycles.
REQ-042 Write, address 0x012345, data 0x3C → region_sel[3]=1, region_wdata=0x3C, region_write=1; data_out unchanged.
REQ-043 Read to region 2 with ready delayed 10 cycles → bus_halt high 11 cycles; ready pulses on regions 0/1/3 meanwhile are ignored.
REQ-044 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted → DONE after 4 ACCESS cycles, data_out=0xFF, bus_error=1; err_clear pulse → bus_error=0.
REQ-045 BUS_TIMEOUT_EN, ready asserted exactly in the timeout cycle → normal data captured, bus_error stays 0.
REQ-046 reset pulsed low mid-ACCESS → all outputs 0 immediately; next bus_enable starts a clean access.
